goertzel_tone_detect: RTL and testbench

//  Downstream consumer of the fixed-bin Goertzel IIR stage. Takes each per-block complex DFT result (Re, Im, valid pulse).

---
 rtl/goertzel_tone_detect_pkg.sv | 21 ++
 rtl/goertzel_tone_detect_if.sv | 31 +++
 rtl/goertzel_tone_detect_mag2.sv | 65 ++++++
 rtl/goertzel_tone_detect.sv | 141 ++++++++++++++
 tb/tb_goertzel_tone_detect.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/goertzel_tone_detect_pkg.sv
// Shared types and helpers for the Goertzel tone detector: FSM state encoding,
// default input width and debounce counter sizing.
package goertzel_tone_detect_pkg;

    localparam int IW_DEFAULT = 32;

    typedef enum logic [1:0] {
        S_OFF = 2'd0,
        S_ARM = 2'd1,
        S_ON  = 2'd2,
        S_REL = 2'd3
    } state_e;

    // Counter must hold the larger of the two debounce lengths.
    function automatic int cnt_width(input int on_count, input int off_count);
        int m;
        m = (on_count > off_count) ? on_count : off_count;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/goertzel_tone_detect_if.sv
// Bundle between a Goertzel bin result source and the tone detector:
// complex sample in, thresholds in, power and detection flags out.
import goertzel_tone_detect_pkg::*;

interface goertzel_tone_detect_if #(
    parameter int IW = IW_DEFAULT
);
    localparam int PW = 2 * IW;

    logic                 i_valid;
    logic signed [IW-1:0] i_re;
    logic signed [IW-1:0] i_im;
    logic        [PW-1:0] i_thr_on;
    logic        [PW-1:0] i_thr_off;
    logic        [PW-1:0] o_power;
    logic                 o_pwr_valid;
    logic                 o_detect;
    logic                 o_onset;
    logic                 o_release;

    modport master (
        output i_valid, i_re, i_im, i_thr_on, i_thr_off,
        input  o_power, o_pwr_valid, o_detect, o_onset, o_release
    );

    modport slave (
        input  i_valid, i_re, i_im, i_thr_on, i_thr_off,
        output o_power, o_pwr_valid, o_detect, o_onset, o_release
    );

endinterface

// File: rtl/goertzel_tone_detect_mag2.sv
// Two-stage |X|^2 = re^2 + im^2 pipeline; accepts a new sample every cycle.
// Reusable for any Goertzel bin.
import goertzel_tone_detect_pkg::*;

module goertzel_tone_detect_mag2 #(
    parameter int IW = IW_DEFAULT,
    localparam int PW = 2 * IW
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_valid,
    input  logic signed [IW-1:0] i_re,
    input  logic signed [IW-1:0] i_im,
    output logic        [PW-1:0] o_power,
    output logic                 o_valid
);

    logic signed [PW-1:0] re_ext_p0;
    logic signed [PW-1:0] im_ext_p0;
    logic signed [PW-1:0] re_sq_p1_q;
    logic signed [PW-1:0] im_sq_p1_q;
    logic                 vld_p1_q;
    logic        [PW-1:0] sum_p1;
    logic        [PW-1:0] power_p2_q;
    logic                 vld_p2_q;

    assign re_ext_p0 = PW'(i_re);
    assign im_ext_p0 = PW'(i_im);

    // Stage 1: squares. Each square is non-negative and below 2^(2IW-2)+1,
    // so the PW-bit product never wraps.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            vld_p1_q <= 1'b0;
        end else begin
            vld_p1_q <= i_valid;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_valid) begin
            re_sq_p1_q <= re_ext_p0 * re_ext_p0;
            im_sq_p1_q <= im_ext_p0 * im_ext_p0;
        end
    end

    // Stage 2: sum, reinterpreted unsigned; worst case 2^(2IW-1) still fits.
    assign sum_p1 = $unsigned(re_sq_p1_q) + $unsigned(im_sq_p1_q);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            vld_p2_q   <= 1'b0;
            power_p2_q <= '0;
        end else begin
            vld_p2_q <= vld_p1_q;
            if (vld_p1_q) begin
                power_p2_q <= sum_p1;
            end
        end
    end

    assign o_power = power_p2_q;
    assign o_valid = vld_p2_q;

endmodule

// File: rtl/goertzel_tone_detect.sv
// Tone detector: Goertzel bin power followed by a hysteretic, debounced
// threshold FSM producing a detect level and onset/release pulses.
import goertzel_tone_detect_pkg::*;

module goertzel_tone_detect #(
    parameter int IW        = IW_DEFAULT,
    parameter int ON_COUNT  = 3,
    parameter int OFF_COUNT = 3
) (
    input logic                    i_clk,
    input logic                    i_rst_n,
    goertzel_tone_detect_if.slave  bus
);

    localparam int PW = 2 * IW;
    localparam int CW = cnt_width(ON_COUNT, OFF_COUNT);

    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] ON_CNT_L  = CW'(ON_COUNT);
    localparam logic [CW-1:0] OFF_CNT_L = CW'(OFF_COUNT);

    logic [PW-1:0] power_p2;
    logic          vld_p2;
    logic          above_p2;
    logic          below_p2;

    state_e        state_q,   state_d;
    logic [CW-1:0] cnt_q,     cnt_d;
    logic          detect_q,  detect_d;
    logic          onset_q,   onset_d;
    logic          release_q, release_d;

    goertzel_tone_detect_mag2 #(
        .IW (IW)
    ) u_mag2 (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_valid (bus.i_valid),
        .i_re    (bus.i_re),
        .i_im    (bus.i_im),
        .o_power (power_p2),
        .o_valid (vld_p2)
    );

    // Equality with the onset threshold counts as above; equality with the
    // release threshold counts as not below.
    assign above_p2 = (power_p2 >= bus.i_thr_on);
    assign below_p2 = (power_p2 <  bus.i_thr_off);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        onset_d   = 1'b0;
        release_d = 1'b0;
        if (vld_p2) begin
            case (state_q)
                S_OFF: begin
                    if (above_p2) begin
                        if (ON_CNT_L == CNT_ONE) begin
                            state_d = S_ON;
                            cnt_d   = '0;
                            onset_d = 1'b1;
                        end else begin
                            state_d = S_ARM;
                            cnt_d   = CNT_ONE;
                        end
                    end
                end
                S_ARM: begin
                    if (above_p2) begin
                        if (cnt_q + CNT_ONE == ON_CNT_L) begin
                            state_d = S_ON;
                            cnt_d   = '0;
                            onset_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end else begin
                        state_d = S_OFF;
                        cnt_d   = '0;
                    end
                end
                S_ON: begin
                    if (below_p2) begin
                        if (OFF_CNT_L == CNT_ONE) begin
                            state_d   = S_OFF;
                            cnt_d     = '0;
                            release_d = 1'b1;
                        end else begin
                            state_d = S_REL;
                            cnt_d   = CNT_ONE;
                        end
                    end
                end
                S_REL: begin
                    if (below_p2) begin
                        if (cnt_q + CNT_ONE == OFF_CNT_L) begin
                            state_d   = S_OFF;
                            cnt_d     = '0;
                            release_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end else begin
                        state_d = S_ON;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = S_OFF;
                    cnt_d   = '0;
                end
            endcase
        end
        detect_d = (state_d == S_ON) || (state_d == S_REL);
    end

    // Stage 3: FSM state and registered flags, one cycle after o_pwr_valid.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q   <= S_OFF;
            cnt_q     <= '0;
            detect_q  <= 1'b0;
            onset_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            detect_q  <= detect_d;
            onset_q   <= onset_d;
            release_q <= release_d;
        end
    end

    assign bus.o_power     = power_p2;
    assign bus.o_pwr_valid = vld_p2;
    assign bus.o_detect    = detect_q;
    assign bus.o_onset     = onset_q;
    assign bus.o_release   = release_q;

endmodule

// File: tb/tb_goertzel_tone_detect.sv
// Scoreboard bench: two detectors (debounce 3/3 and 1/1) share one stimulus
// stream; expected power and per-frame flags are queued and checked by a monitor.
module tb_goertzel_tone_detect;

    localparam int IW = 12;
    localparam int PW = 2 * IW;

    typedef struct {
        longint pwr;
        int     due;
    } pwr_exp_t;

    typedef struct {
        bit det;
        bit on;
        bit rel;
    } fsm_exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    goertzel_tone_detect_if #(.IW(IW)) ifa ();
    goertzel_tone_detect_if #(.IW(IW)) ifb ();

    goertzel_tone_detect #(.IW(IW), .ON_COUNT(3), .OFF_COUNT(3)) dut_a (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (ifa)
    );

    goertzel_tone_detect #(.IW(IW), .ON_COUNT(1), .OFF_COUNT(1)) dut_b (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (ifb)
    );

    always #5 clk = ~clk;

    int       checks   = 0;
    int       failures = 0;
    int       cyc      = 0;
    bit       rst_edge = 1'b0;

    pwr_exp_t pwr_q[$];
    fsm_exp_t fsm_qa[$];
    fsm_exp_t fsm_qb[$];

    // Reference model state (driver side)
    longint   thr_on  = 100;
    longint   thr_off = 50;
    int       on_n[2]  = '{3, 1};
    int       off_n[2] = '{3, 1};
    bit       mdet[2]  = '{0, 0};
    int       mrun[2]  = '{0, 0};

    // Monitor side
    bit       pend[2]     = '{0, 0};
    bit       last_det[2] = '{0, 0};

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_edge <= !rst_n;
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_missing(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=none required=queued expectation (cycle %0d)", name, cyc);
    endtask

    task automatic drv(input bit v, input int re, input int im);
        ifa.i_valid = v;  ifa.i_re = IW'(re);  ifa.i_im = IW'(im);
        ifb.i_valid = v;  ifb.i_re = IW'(re);  ifb.i_im = IW'(im);
    endtask

    task automatic set_thr(input longint on, input longint off);
        thr_on  = on;
        thr_off = off;
        ifa.i_thr_on = PW'(on);  ifa.i_thr_off = PW'(off);
        ifb.i_thr_on = PW'(on);  ifb.i_thr_off = PW'(off);
    endtask

    // Debounced hysteresis: consecutive qualifying frames, run cleared on a miss.
    task automatic model_frame(input longint p);
        for (int d = 0; d < 2; d++) begin
            fsm_exp_t e;
            e.on  = 1'b0;
            e.rel = 1'b0;
            if (!mdet[d]) begin
                mrun[d] = (p >= thr_on) ? mrun[d] + 1 : 0;
                if (mrun[d] == on_n[d]) begin
                    mdet[d] = 1'b1;
                    mrun[d] = 0;
                    e.on    = 1'b1;
                end
            end else begin
                mrun[d] = (p < thr_off) ? mrun[d] + 1 : 0;
                if (mrun[d] == off_n[d]) begin
                    mdet[d] = 1'b0;
                    mrun[d] = 0;
                    e.rel   = 1'b1;
                end
            end
            e.det = mdet[d];
            if (d == 0) fsm_qa.push_back(e);
            else        fsm_qb.push_back(e);
        end
    endtask

    task automatic frame(input int re, input int im);
        longint p;
        pwr_exp_t pe;
        @(posedge clk);
        #1;
        drv(1'b1, re, im);
        p      = longint'(re) * re + longint'(im) * im;
        pe.pwr = p;
        pe.due = cyc + 2;
        pwr_q.push_back(pe);
        model_frame(p);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            drv(1'b0, 0, 0);
        end
    endtask

    task automatic do_reset(input int n);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        drv(1'b1, $urandom_range(0, 4095) - 2048, $urandom_range(0, 4095) - 2048);
        repeat (n) @(posedge clk);
        @(negedge clk);
        #2;
        pwr_q.delete();
        fsm_qa.delete();
        fsm_qb.delete();
        mdet = '{0, 0};
        mrun = '{0, 0};
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drv(1'b0, 0, 0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        idle(1);
        while ((pwr_q.size() != 0 || fsm_qa.size() != 0 || fsm_qb.size() != 0) && n < 40) begin
            @(posedge clk);
            n++;
        end
        if (n >= 40) fail_missing("drain_timeout");
        idle(2);
    endtask

    task automatic mon_fsm(input int d, input logic det, input logic on, input logic rel);
        fsm_exp_t e;
        int       qs;
        if (rst_edge) begin
            chk($sformatf("rst_detect_%0d", d),  det, 0);
            chk($sformatf("rst_onset_%0d", d),   on,  0);
            chk($sformatf("rst_release_%0d", d), rel, 0);
            pend[d]     = 1'b0;
            last_det[d] = 1'b0;
        end else if (pend[d]) begin
            qs = (d == 0) ? fsm_qa.size() : fsm_qb.size();
            if (qs == 0) begin
                fail_missing($sformatf("fsm_underflow_%0d", d));
            end else begin
                e = (d == 0) ? fsm_qa.pop_front() : fsm_qb.pop_front();
                chk($sformatf("detect_%0d", d),  det, e.det);
                chk($sformatf("onset_%0d", d),   on,  e.on);
                chk($sformatf("release_%0d", d), rel, e.rel);
                last_det[d] = e.det;
            end
        end else begin
            chk($sformatf("idle_onset_%0d", d),   on,  0);
            chk($sformatf("idle_release_%0d", d), rel, 0);
            chk($sformatf("idle_detect_%0d", d),  det, last_det[d]);
        end
    endtask

    task automatic mon_pwr();
        pwr_exp_t e;
        if (rst_edge) begin
            chk("rst_power_a", ifa.o_power, 0);
            chk("rst_pvalid_a", ifa.o_pwr_valid, 0);
            chk("rst_power_b", ifb.o_power, 0);
            chk("rst_pvalid_b", ifb.o_pwr_valid, 0);
            return;
        end
        if (ifa.o_pwr_valid || ifb.o_pwr_valid) begin
            if (pwr_q.size() == 0) begin
                fail_missing("pwr_unexpected");
            end else begin
                e = pwr_q.pop_front();
                chk("pvalid_a", ifa.o_pwr_valid, 1);
                chk("pvalid_b", ifb.o_pwr_valid, 1);
                chk("power_a", ifa.o_power, e.pwr);
                chk("power_b", ifb.o_power, e.pwr);
                chk("pwr_latency", cyc, e.due);
            end
        end
        pend[0] = ifa.o_pwr_valid;
        pend[1] = ifb.o_pwr_valid;
    endtask

    always @(negedge clk) begin
        mon_fsm(0, ifa.o_detect, ifa.o_onset, ifa.o_release);
        mon_fsm(1, ifb.o_detect, ifb.o_onset, ifb.o_release);
        mon_pwr();
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=running required=finished (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int re;
        int im;
        int on_t;

        drv(1'b1, 5, 5);
        set_thr(100, 50);
        do_reset(4);

        // Pipeline values, back to back, including most-negative inputs
        frame(3, 4);
        frame(-2048, -2048);
        drain();
        do_reset(2);

        // Debounced onset: 121,121,49,121,121,121
        frame(11, 0);   idle(2);
        frame(0, -11);  idle(2);
        frame(7, 0);    idle(3);
        frame(-11, 0);  idle(1);
        frame(11, 0);   idle(4);
        frame(0, 11);   idle(2);

        // Hysteresis: 74 x4 stays on, 40 x3 releases
        for (int i = 0; i < 4; i++) begin frame(5, 7); idle(1); end
        for (int i = 0; i < 3; i++) begin frame(6, -2); idle(2); end
        drain();

        // Threshold equality: 100 is above, 50 is not below, 49 is below
        for (int i = 0; i < 3; i++) begin frame(10, 0); idle(1); end
        for (int i = 0; i < 3; i++) begin frame(5, -5); idle(1); end
        for (int i = 0; i < 3; i++) begin frame(-7, 0); idle(1); end
        drain();

        // Back-to-back frames with a reset arriving mid-stream
        frame(11, 0);
        frame(11, 0);
        do_reset(2);
        frame(11, 0);
        frame(0, 11);
        frame(-11, 0);
        drain();

        // Alternating strong / silent frames
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) frame(11, 0);
            else            frame(0, 0);
            idle(i % 3);
        end
        drain();

        // Randomized frames, gaps and thresholds
        for (int blk = 0; blk < 5; blk++) begin
            on_t = $urandom_range(60, 200);
            set_thr(on_t, $urandom_range(20, 220));
            for (int i = 0; i < 60; i++) begin
                if ($urandom_range(0, 9) == 0) begin
                    re = $urandom_range(0, 4095) - 2048;
                    im = $urandom_range(0, 4095) - 2048;
                end else begin
                    re = $urandom_range(0, 24) - 12;
                    im = $urandom_range(0, 24) - 12;
                end
                frame(re, im);
                if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 3));
            end
            drain();
        end

        idle(3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
